// File: rtl/stream2sync.sv
// Rebuilds raw pixel + hsync/vsync timing from an AXI video stream.
// A programmable timing generator paces the stream; it never waits for it.
module stream2sync #(
  parameter bit          OPT_INVERT_HSYNC = 1'b0,
  parameter bit          OPT_INVERT_VSYNC = 1'b0,
  parameter bit          OPT_TUSER_IS_SOF = 1'b0,
  parameter int unsigned LGDIM            = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,

  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [23:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  input  logic             S_AXIS_TUSER,

  input  logic [LGDIM-1:0] i_width,
  input  logic [LGDIM-1:0] i_hfront,
  input  logic [LGDIM-1:0] i_hsync,
  input  logic [LGDIM-1:0] i_raw_width,
  input  logic [LGDIM-1:0] i_height,
  input  logic [LGDIM-1:0] i_vfront,
  input  logic [LGDIM-1:0] i_vsync,
  input  logic [LGDIM-1:0] i_raw_height,

  output logic             o_pix_valid,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [23:0]      o_pixel,
  output logic             o_locked,
  output logic             o_underflow
);

  typedef enum logic [1:0] {StSync, StWait, StLocked} state_e;

  state_e           state_q;
  logic [LGDIM-1:0] hpos_q, vpos_q;
  logic [LGDIM-1:0] width_q, hfront_q, hsync_q, raw_width_q;
  logic [LGDIM-1:0] height_q, vfront_q, vsync_q, raw_height_q;

  logic [LGDIM-1:0] h_last, v_last;
  logic             line_end, frame_end;
  logic             active, hs, vs;
  logic             last_col, last_row, at_origin;
  logic             line_mark, frame_mark, line_exp, frame_exp;
  logic             beat, underflow, marker_err, lost, boundary;

  // A zero raw dimension behaves as one; >= lets a shrinking mode recover.
  always_comb begin
    h_last    = (raw_width_q == '0) ? '0 : raw_width_q - LGDIM'(1);
    v_last    = (raw_height_q == '0) ? '0 : raw_height_q - LGDIM'(1);
    line_end  = (hpos_q >= h_last);
    frame_end = line_end && (vpos_q >= v_last);
  end

  always_comb begin
    active    = (hpos_q < width_q) && (vpos_q < height_q);
    hs        = (hpos_q >= hfront_q) && (hpos_q < hsync_q);
    vs        = (vpos_q >= vfront_q) && (vpos_q < vsync_q);
    last_col  = (hpos_q == width_q - LGDIM'(1));
    last_row  = (vpos_q == height_q - LGDIM'(1));
    at_origin = (hpos_q == '0) && (vpos_q == '0);
  end

  // Marker roles swap between the two framing conventions.
  always_comb begin
    if (OPT_TUSER_IS_SOF) begin
      line_mark  = S_AXIS_TLAST;
      frame_mark = S_AXIS_TUSER;
      frame_exp  = at_origin;
      boundary   = S_AXIS_TVALID && S_AXIS_TUSER;
    end else begin
      line_mark  = S_AXIS_TUSER;
      frame_mark = S_AXIS_TLAST;
      frame_exp  = last_col && last_row;
      boundary   = S_AXIS_TVALID && S_AXIS_TLAST;
    end
    line_exp = last_col;
  end

  always_comb begin
    beat       = (state_q == StLocked) && active && S_AXIS_TVALID;
    underflow  = (state_q == StLocked) && active && !S_AXIS_TVALID;
    marker_err = beat && ((line_mark != line_exp) || (frame_mark != frame_exp));
    lost       = underflow || marker_err;
  end

  // In SOF mode the start-of-frame beat is held back so it can be shown at (0, 0).
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    unique case (state_q)
      StSync:   S_AXIS_TREADY = OPT_TUSER_IS_SOF ? !(S_AXIS_TVALID && S_AXIS_TUSER) : 1'b1;
      StWait:   S_AXIS_TREADY = 1'b0;
      StLocked: S_AXIS_TREADY = active;
      default:  S_AXIS_TREADY = 1'b0;
    endcase
    if (!i_reset_n) begin
      S_AXIS_TREADY = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= StSync;
      hpos_q       <= '0;
      vpos_q       <= '0;
      width_q      <= i_width;
      hfront_q     <= i_hfront;
      hsync_q      <= i_hsync;
      raw_width_q  <= i_raw_width;
      height_q     <= i_height;
      vfront_q     <= i_vfront;
      vsync_q      <= i_vsync;
      raw_height_q <= i_raw_height;
      o_pix_valid  <= 1'b0;
      o_hsync      <= OPT_INVERT_HSYNC;
      o_vsync      <= OPT_INVERT_VSYNC;
      o_pixel      <= '0;
      o_locked     <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      if (frame_end) begin
        hpos_q       <= '0;
        vpos_q       <= '0;
        width_q      <= i_width;
        hfront_q     <= i_hfront;
        hsync_q      <= i_hsync;
        raw_width_q  <= i_raw_width;
        height_q     <= i_height;
        vfront_q     <= i_vfront;
        vsync_q      <= i_vsync;
        raw_height_q <= i_raw_height;
      end else if (line_end) begin
        hpos_q <= '0;
        vpos_q <= vpos_q + LGDIM'(1);
      end else begin
        hpos_q <= hpos_q + LGDIM'(1);
      end

      o_pix_valid <= active;
      o_hsync     <= hs ^ OPT_INVERT_HSYNC;
      o_vsync     <= vs ^ OPT_INVERT_VSYNC;
      o_pixel     <= beat ? S_AXIS_TDATA : '0;
      o_underflow <= underflow;
      // Tracks the pixel now on o_pixel, so a failing beat already shows unlocked.
      o_locked    <= (state_q == StLocked) && !lost;

      // WAIT hands over on the wrap so the (0, 0) pixel is already accepted.
      unique case (state_q)
        StSync:   if (boundary)  state_q <= StWait;
        StWait:   if (frame_end) state_q <= StLocked;
        StLocked: if (lost)      state_q <= StSync;
        default:                 state_q <= StSync;
      endcase
    end
  end

endmodule
